// File: rtl/buzzer_pkg.sv
// Shared definitions for the melody sequencer: note codes, FSM states,
// the song ROM entry layout and the fixed song contents.
package buzzer_pkg;

   // Note codes understood by the tone generator
   localparam logic [2:0] NOTE_REST = 3'd0;
   localparam logic [2:0] NOTE_DO   = 3'd1;
   localparam logic [2:0] NOTE_RE   = 3'd2;
   localparam logic [2:0] NOTE_MI   = 3'd3;
   localparam logic [2:0] NOTE_SOL  = 3'd4;
   localparam logic [2:0] NOTE_LA   = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_PLAY   = 2'd2,
      ST_GAP    = 2'd3
   } seqState_t;

   // One song step: which note and how many beats it lasts (1..4)
   typedef struct packed {
      logic [2:0] note;
      logic [2:0] beats;
   } romEntry_t;

   // Fixed song; unused entries are single-beat rests
   function automatic romEntry_t songRom(input logic [3:0] idx);
      romEntry_t e;
      case (idx)
         4'd0:    e = '{note: NOTE_MI,   beats: 3'd1};
         4'd1:    e = '{note: NOTE_RE,   beats: 3'd1};
         4'd2:    e = '{note: NOTE_DO,   beats: 3'd1};
         4'd3:    e = '{note: NOTE_RE,   beats: 3'd1};
         4'd4:    e = '{note: NOTE_MI,   beats: 3'd1};
         4'd5:    e = '{note: NOTE_MI,   beats: 3'd1};
         4'd6:    e = '{note: NOTE_MI,   beats: 3'd2};
         4'd7:    e = '{note: NOTE_REST, beats: 3'd1};
         default: e = '{note: NOTE_REST, beats: 3'd1};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Cycle/beat counter used to time notes and gaps. The cycle counter wraps
// every `period` cycles (one beat); `done` fires on the last cycle of the
// `target`-th beat. `clear` restarts both counters from zero.
module beat_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic [CW-1:0] period,
   input  logic [2:0]    target,
   output logic          beatTick,
   output logic          done
);

   logic [CW-1:0] cycleCnt_r;
   logic [2:0]    beatCnt_r;

   assign beatTick = (cycleCnt_r == (period - CW'(1)));
   assign done     = beatTick && (beatCnt_r == (target - 3'd1));

   // Advance the cycle counter, rolling into the beat counter each beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt_r <= '0;
         beatCnt_r  <= 3'd0;
      end else if (clear) begin
         cycleCnt_r <= '0;
         beatCnt_r  <= 3'd0;
      end else if (beatTick) begin
         cycleCnt_r <= '0;
         beatCnt_r  <= beatCnt_r + 3'd1;
      end else begin
         cycleCnt_r <= cycleCnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: arbitrates the five note buttons against the built-in
// song and produces a registered note code plus tone enable. Buttons always
// preempt the song; the song resumes at the same entry once they are released.
module melody_sequencer
   import buzzer_pkg::*;
#(
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 5_000_000,
   parameter int SONG_LEN    = 8,
   parameter int LOOP        = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnU,
   input  logic       btnL,
   input  logic       btnC,
   input  logic       btnR,
   input  logic       btnD,
   input  logic       start,
   input  logic       stop,
   output logic [2:0] note,
   output logic       note_on,
   output logic       playing,
   output logic [3:0] song_idx
);

   localparam int MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC);
   // A period equal to 2**CW truncates to 0; the counter then wraps at the
   // full range, which still yields the right period.
   localparam logic [CW-1:0] BEAT_PERIOD = CW'(BEAT_CYCLES);
   localparam logic [CW-1:0] GAP_PERIOD  = CW'(GAP_CYCLES);
   localparam logic [3:0]    LAST_IDX    = 4'(SONG_LEN - 1);

   seqState_t  state_r;
   seqState_t  nextState_s;
   logic [2:0] note_r;
   logic       noteOn_r;
   logic       playing_r;
   logic [3:0] songIdx_r;
   logic       resume_r;
   logic [2:0] beats_r;

   logic          anyBtn_s;
   logic [2:0]    btnNote_s;
   logic [3:0]    nextSongIdx_s;
   logic          nextResume_s;
   logic [2:0]    nextNote_s;
   logic          nextNoteOn_s;
   logic          nextPlaying_s;
   romEntry_t     nextEntry_s;
   logic          timerClear_s;
   logic [CW-1:0] timerPeriod_s;
   logic [2:0]    timerTarget_s;
   logic          timerTick_s;
   logic          timerDone_s;
   logic          segmentEnd_s;

   beat_timer #(.CW(CW)) uTimer (
      .clk      (clk),
      .rst_n    (reset),
      .clear    (timerClear_s),
      .period   (timerPeriod_s),
      .target   (timerTarget_s),
      .beatTick (timerTick_s),
      .done     (timerDone_s)
   );

   assign segmentEnd_s = timerTick_s && timerDone_s;

   // Fixed-priority button encoder: U > L > C > R > D
   always_comb begin
      anyBtn_s  = btnU | btnL | btnC | btnR | btnD;
      btnNote_s = NOTE_REST;
      if (btnU) begin
         btnNote_s = NOTE_DO;
      end else if (btnL) begin
         btnNote_s = NOTE_RE;
      end else if (btnC) begin
         btnNote_s = NOTE_MI;
      end else if (btnR) begin
         btnNote_s = NOTE_SOL;
      end else if (btnD) begin
         btnNote_s = NOTE_LA;
      end else begin
         btnNote_s = NOTE_REST;
      end
   end

   // Next-state, song position and resume-flag logic; stop wins over everything
   always_comb begin
      nextState_s   = state_r;
      nextSongIdx_s = songIdx_r;
      nextResume_s  = resume_r;
      if (stop) begin
         nextState_s   = ST_IDLE;
         nextSongIdx_s = 4'd0;
         nextResume_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (anyBtn_s) begin
                  nextState_s = ST_MANUAL;
               end else if (start) begin
                  nextState_s   = ST_PLAY;
                  nextSongIdx_s = 4'd0;
               end else begin
                  nextState_s = ST_IDLE;
               end
            end
            ST_MANUAL: begin
               // start only arms a new song if none is already pending
               if (start && !resume_r) begin
                  nextResume_s  = 1'b1;
                  nextSongIdx_s = 4'd0;
               end else begin
                  nextResume_s = resume_r;
               end
               if (anyBtn_s) begin
                  nextState_s = ST_MANUAL;
               end else if (nextResume_s) begin
                  nextState_s  = ST_PLAY;
                  nextResume_s = 1'b0;
               end else begin
                  nextState_s = ST_IDLE;
               end
            end
            ST_PLAY: begin
               if (anyBtn_s) begin
                  nextState_s  = ST_MANUAL;
                  nextResume_s = 1'b1;
               end else if (segmentEnd_s) begin
                  nextState_s = ST_GAP;
               end else begin
                  nextState_s = ST_PLAY;
               end
            end
            ST_GAP: begin
               if (anyBtn_s) begin
                  nextState_s  = ST_MANUAL;
                  nextResume_s = 1'b1;
               end else if (segmentEnd_s) begin
                  if (songIdx_r < LAST_IDX) begin
                     nextState_s   = ST_PLAY;
                     nextSongIdx_s = songIdx_r + 4'd1;
                  end else if (LOOP != 0) begin
                     nextState_s   = ST_PLAY;
                     nextSongIdx_s = 4'd0;
                  end else begin
                     nextState_s   = ST_IDLE;
                     nextSongIdx_s = 4'd0;
                     nextResume_s  = 1'b0;
                  end
               end else begin
                  nextState_s = ST_GAP;
               end
            end
            default: begin
               nextState_s   = ST_IDLE;
               nextSongIdx_s = 4'd0;
               nextResume_s  = 1'b0;
            end
         endcase
      end
   end

   // Output values for the state being entered, plus timer control
   always_comb begin
      nextEntry_s   = songRom(nextSongIdx_s);
      nextNote_s    = NOTE_REST;
      nextNoteOn_s  = 1'b0;
      nextPlaying_s = 1'b0;
      case (nextState_s)
         ST_IDLE: begin
            nextNote_s    = NOTE_REST;
            nextNoteOn_s  = 1'b0;
            nextPlaying_s = 1'b0;
         end
         ST_MANUAL: begin
            nextNote_s    = btnNote_s;
            nextNoteOn_s  = 1'b1;
            nextPlaying_s = nextResume_s;
         end
         ST_PLAY: begin
            nextNote_s    = nextEntry_s.note;
            nextNoteOn_s  = (nextEntry_s.note != NOTE_REST);
            nextPlaying_s = 1'b1;
         end
         ST_GAP: begin
            nextNote_s    = NOTE_REST;
            nextNoteOn_s  = 1'b0;
            nextPlaying_s = 1'b1;
         end
         default: begin
            nextNote_s    = NOTE_REST;
            nextNoteOn_s  = 1'b0;
            nextPlaying_s = 1'b0;
         end
      endcase
      // Every state entry restarts timing; idle/manual keep the timer parked
      timerClear_s  = (nextState_s != state_r) || (state_r == ST_IDLE) ||
                      (state_r == ST_MANUAL);
      timerPeriod_s = (state_r == ST_GAP) ? GAP_PERIOD : BEAT_PERIOD;
      timerTarget_s = (state_r == ST_PLAY) ? beats_r : 3'd1;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         note_r    <= NOTE_REST;
         noteOn_r  <= 1'b0;
         playing_r <= 1'b0;
         songIdx_r <= 4'd0;
         resume_r  <= 1'b0;
         beats_r   <= 3'd1;
      end else begin
         state_r   <= nextState_s;
         note_r    <= nextNote_s;
         noteOn_r  <= nextNoteOn_s;
         playing_r <= nextPlaying_s;
         songIdx_r <= nextSongIdx_s;
         resume_r  <= nextResume_s;
         beats_r   <= nextEntry_s.beats;
      end
   end

   assign note     = note_r;
   assign note_on  = noteOn_r;
   assign playing  = playing_r;
   assign song_idx = songIdx_r;

endmodule
